// File: rtl/elliptic_curve_structs.sv
// Shared types for the elliptic-curve field-arithmetic datapath.
//   arb_state_t            : sequencing states of the shared-multiplier arbiter
//   mul_req_t              : operand pair handed to a Booth multiplier
//   DEFAULT_TIMEOUT_CYCLES : default watchdog limit for a multiplier operation
package elliptic_curve_structs;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LAUNCH,
        WAIT,
        RESP
    } arb_state_t;

    localparam int MUL_WIDTH = 128;

    typedef struct packed {
        logic [MUL_WIDTH-1:0] a;
        logic [MUL_WIDTH-1:0] b;
    } mul_req_t;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/booth_mul_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Searches the request vector starting at ptr and moving upward with wrap;
// the first set bit wins.
//   req   in  NREQ   request vector
//   ptr   in  IDX_W  highest-priority index for this pick
//   grant out NREQ   one-hot winner (all zero when no request)
//   idx   out IDX_W  index of the winner (0 when no request)
module rr_picker
    import elliptic_curve_structs::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    // Walk from the farthest offset back to ptr so the nearest requester
    // (smallest offset from ptr) is the last one written and therefore wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            int j;
            j = int'(ptr) + off;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth multiplier wrapper between NREQ field-arithmetic
// requesters. A round-robin winner's operands are latched, the multiplier is
// cleared, launched and waited on, and the 2*WIDTH product is returned to the
// winner with a one-cycle valid pulse.
//
// Optional build macro: MUL_TIMEOUT_EN adds a watchdog that abandons a
// multiplication after TIMEOUT_CYCLES cycles in WAIT and reports rsp_err.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   req         per-requester request, held with stable operands until ack
//   req_a/req_b packed operands, slice i belongs to requester i
//   ack         one-hot pulse: operands captured
//   rsp_valid   one-hot pulse: rsp_ab holds the product for that requester
//   rsp_ab      product (meaningful only with rsp_valid)
//   rsp_err     timeout flag qualifying rsp_valid (0 without the watchdog)
//   busy        high in every state except IDLE
//   mul_rst     local clear to the multiplier (also high during reset)
//   mul_en      multiplier enable
//   mul_a/mul_b multiplier operands
//   mul_ab      multiplier product
//   mul_done    multiplier done
module booth_mul_arbiter
    import elliptic_curve_structs::*;
#(
    parameter int NREQ           = 4,
    parameter int WIDTH          = MUL_WIDTH,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_ab,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  mul_rst,
    output logic                  mul_en,
    output logic [WIDTH-1:0]      mul_a,
    output logic [WIDTH-1:0]      mul_b,
    input  logic [2*WIDTH-1:0]    mul_ab,
    input  logic                  mul_done
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_t         state;
    arb_state_t         state_n;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_next;
    logic [IDX_W-1:0]   pick_idx;
    logic [NREQ-1:0]    pick_grant;
    logic [NREQ-1:0]    owner;
    logic               any_req;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [2*WIDTH-1:0] ab_q;

    assign any_req = |req;

    rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_picker (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Pointer moves just past the winner so it has lowest priority next time.
    assign ptr_next = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
                sel_a = req_a[i*WIDTH +: WIDTH];
                sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUL_TIMEOUT_EN
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TCNT_W-1:0] tcnt;
    logic              err_q;
    logic              timed_out;

    assign timed_out = (tcnt == TCNT_W'(TIMEOUT_CYCLES));
`else
    localparam int timeout_unused = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (any_req) state_n = CLR;
            CLR:     state_n = LAUNCH;
            LAUNCH:  state_n = WAIT;
            WAIT: begin
                if (mul_done) begin
                    state_n = RESP;
                end
`ifdef MUL_TIMEOUT_EN
                else if (timed_out) begin
                    state_n = RESP;
                end
`endif
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr   <= '0;
            op_a  <= '0;
            op_b  <= '0;
            owner <= '0;
            ab_q  <= '0;
`ifdef MUL_TIMEOUT_EN
            tcnt  <= '0;
            err_q <= 1'b0;
`endif
        end else begin
            if (state == IDLE && any_req) begin
                op_a  <= sel_a;
                op_b  <= sel_b;
                owner <= pick_grant;
                ptr   <= ptr_next;
`ifdef MUL_TIMEOUT_EN
                err_q <= 1'b0;
`endif
            end
`ifdef MUL_TIMEOUT_EN
            if (state == LAUNCH) begin
                tcnt <= '0;
            end
`endif
            // A done arriving on the same cycle as the watchdog limit wins.
            if (state == WAIT) begin
                if (mul_done) begin
                    ab_q <= mul_ab;
                end
`ifdef MUL_TIMEOUT_EN
                else if (timed_out) begin
                    ab_q  <= '0;
                    err_q <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
`endif
            end
        end
    end

    // mul_rst also follows reset so the multiplier is held cleared with us.
    always_comb begin
        ack       = '0;
        rsp_valid = '0;
        mul_en    = 1'b0;
        mul_rst   = reset;
        busy      = (state != IDLE);
        unique case (state)
            CLR: begin
                ack     = owner;
                mul_rst = 1'b1;
            end
            LAUNCH:  mul_en = 1'b1;
            WAIT:    mul_en = 1'b1;
            RESP:    rsp_valid = owner;
            default: ;
        endcase
    end

`ifdef MUL_TIMEOUT_EN
    assign rsp_err = (state == RESP) & err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign rsp_ab = ab_q;
    assign mul_a  = op_a;
    assign mul_b  = op_b;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a stub one-shot multiplier of
// configurable latency. Build with MUL_TIMEOUT_EN to include the watchdog case.
module tb_booth_mul_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 128;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } op_t;

    typedef struct {
        logic [2*W-1:0] ab;
        logic           err;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_ab;
    logic              rsp_err;
    logic              busy;
    logic              mul_rst;
    logic              mul_en;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_ab;
    logic              mul_done;

    booth_mul_arbiter #(
        .NREQ           (NREQ),
        .WIDTH          (W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .ack       (ack),
        .rsp_valid (rsp_valid),
        .rsp_ab    (rsp_ab),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mul_rst   (mul_rst),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_ab    (mul_ab),
        .mul_done  (mul_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub multiplier: captures operands on the first enable after a clear,
    // then ignores enable until the next clear; done stays high until cleared.
    int           lat        = 3;
    logic         never_done = 1'b0;
    logic         spur       = 1'b0;
    logic         armed      = 1'b1;
    int           scnt       = 0;
    logic [2*W-1:0] st_ab    = '0;

    always @(posedge clk) begin
        if (mul_rst) begin
            armed <= 1'b1;
            scnt  <= 0;
            st_ab <= '0;
        end else if (mul_en && armed) begin
            armed <= 1'b0;
            scnt  <= 1;
            st_ab <= (2*W)'(mul_a) * (2*W)'(mul_b);
        end else if (!armed && scnt < lat) begin
            scnt <= scnt + 1;
        end
    end

    assign mul_ab   = st_ab;
    assign mul_done = spur | (!armed && (scnt >= lat) && !never_done);

    op_t  op_q [NREQ][$];
    exp_t exp_q[NREQ][$];
    int   ack_log[$];
    int   ack_cyc[NREQ];
    int   rsp_cyc[NREQ];
    int   ack_cnt = 0;
    int   rsp_cnt = 0;
    int   rst_cnt = 0;
    int   iss_cyc = 0;
    int   total   = 0;
    int   bad     = 0;

    task automatic check_eq(input string tag, input logic [2*W-1:0] got,
                            input logic [2*W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NREQ; i++) begin
            if (op_q[i].size() != 0) begin
                req[i]            = 1'b1;
                req_a[i*W +: W]   = op_q[i][0].a;
                req_b[i*W +: W]   = op_q[i][0].b;
            end else begin
                req[i] = 1'b0;
            end
        end
    endtask

    // One clock: observe outputs mid-cycle, update requesters, score responses.
    task automatic step();
        exp_t e;
        @(negedge clk);
        #1;
        if (mul_rst) rst_cnt++;
        if (ack != '0) begin
            check_eq("ack_onehot", {255'd0, $onehot(ack)}, 256'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) begin
                    ack_cnt++;
                    ack_cyc[i] = cyc;
                    ack_log.push_back(i);
                    if (op_q[i].size() != 0) void'(op_q[i].pop_front());
                end
            end
        end
        if (rsp_valid != '0) begin
            check_eq("rsp_onehot", {255'd0, $onehot(rsp_valid)}, 256'd1);
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_valid[i]) begin
                    rsp_cnt++;
                    rsp_cyc[i] = cyc;
                    if (exp_q[i].size() == 0) begin
                        check_eq("rsp_unexpected", {252'd0, rsp_valid}, 256'd0);
                    end else begin
                        e = exp_q[i].pop_front();
                        check_eq("rsp_ab", rsp_ab, e.ab);
                        check_eq("rsp_err", {255'd0, rsp_err}, {255'd0, e.err});
                    end
                end
            end
        end
        drive_reqs();
    endtask

    task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic expect_timeout);
        op_t  o;
        exp_t e;
        o.a = a;
        o.b = b;
        e.ab  = expect_timeout ? '0 : (2*W)'(a) * (2*W)'(b);
        e.err = expect_timeout;
        op_q[i].push_back(o);
        exp_q[i].push_back(e);
        iss_cyc = cyc;
        drive_reqs();
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_cnt < n && k < budget) begin
            step();
            k++;
        end
        if (rsp_cnt < n) check_eq("rsp_wait_expired", rsp_cnt, n);
    endtask

    task automatic wait_acks(input int n, input int budget);
        int k;
        k = 0;
        while (ack_cnt < n && k < budget) begin
            step();
            k++;
        end
        if (ack_cnt < n) check_eq("ack_wait_expired", ack_cnt, n);
    endtask

    initial begin
        int base;
        int base_rst;
        int ic;
        int exp_order[5];
        logic [W-1:0] max_v;

        reset = 1'b1;
        req   = '0;
        req_a = '0;
        req_b = '0;
        repeat (3) step();

        // Reset state
        check_eq("rst_ack", {252'd0, ack}, 256'd0);
        check_eq("rst_rsp_valid", {252'd0, rsp_valid}, 256'd0);
        check_eq("rst_rsp_ab", rsp_ab, 256'd0);
        check_eq("rst_rsp_err", {255'd0, rsp_err}, 256'd0);
        check_eq("rst_busy", {255'd0, busy}, 256'd0);
        check_eq("rst_mul_en", {255'd0, mul_en}, 256'd0);
        check_eq("rst_mul_rst", {255'd0, mul_rst}, 256'd1);
        check_eq("rst_mul_a", {128'd0, mul_a}, 256'd0);
        reset = 1'b0;
        step();

        // Contention: all four requesting, requester 0 has a second op queued
        lat = 3;
        ack_log.delete();
        base = rsp_cnt;
        issue(0, 128'd2, 128'd3, 1'b0);
        issue(1, 128'd4, 128'd5, 1'b0);
        issue(2, 128'd6, 128'd7, 1'b0);
        issue(3, 128'd8, 128'd9, 1'b0);
        issue(0, 128'd10, 128'd11, 1'b0);
        wait_rsps(base + 5, 200);
        exp_order = '{0, 1, 2, 3, 0};
        check_eq("ack_log_size", ack_log.size(), 5);
        for (int k = 0; k < 5 && k < ack_log.size(); k++) begin
            check_eq($sformatf("ack_order_%0d", k), ack_log[k], exp_order[k]);
        end

        // Single request with latency 10
        lat = 10;
        step();
        base     = rsp_cnt;
        base_rst = rst_cnt;
        issue(2, 128'd7, 128'd9, 1'b0);
        ic = iss_cyc;
        wait_rsps(base + 1, 100);
        check_eq("single_ack_lat", ack_cyc[2] - ic, 1);
        check_eq("single_rsp_lat", rsp_cyc[2] - ic, 13);
        check_eq("single_mul_rst_pulses", rst_cnt - base_rst, 1);

        // Back-to-back on one requester; second must not see the stale result
        lat = 3;
        step();
        max_v = '1;
        base = rsp_cnt;
        issue(1, max_v, max_v, 1'b0);
        issue(1, 128'd3, 128'd5, 1'b0);
        wait_rsps(base + 2, 100);

        // Spurious done while idle and in CLR
        lat = 4;
        step();
        spur = 1'b1;
        repeat (2) step();
        base = ack_cnt;
        issue(0, 128'd11, 128'd13, 1'b0);
        ic = iss_cyc;
        wait_acks(base + 1, 10);
        spur = 1'b0;
        base = rsp_cnt;
        wait_rsps(base + 1, 100);
        check_eq("spur_rsp_lat", rsp_cyc[0] - ic, 3 + 4);

        // Reset in WAIT aborts the operation
        lat = 10;
        step();
        base = ack_cnt;
        issue(3, 128'd21, 128'd22, 1'b0);
        wait_acks(base + 1, 10);
        repeat (2) step();
        check_eq("abort_in_wait_en", {255'd0, mul_en}, 256'd1);
        reset = 1'b1;
        base = rsp_cnt;
        step();
        check_eq("abort_busy", {255'd0, busy}, 256'd0);
        check_eq("abort_mul_en", {255'd0, mul_en}, 256'd0);
        check_eq("abort_mul_rst", {255'd0, mul_rst}, 256'd1);
        check_eq("abort_rsp_valid", {252'd0, rsp_valid}, 256'd0);
        check_eq("abort_rsp_ab", rsp_ab, 256'd0);
        check_eq("abort_mul_a", {128'd0, mul_a}, 256'd0);
        exp_q[3].delete();
        reset = 1'b0;
        repeat (20) step();
        check_eq("abort_no_rsp", rsp_cnt, base);
        issue(3, 128'd100, 128'd200, 1'b0);
        wait_rsps(base + 1, 100);

`ifdef MUL_TIMEOUT_EN
        // Watchdog: multiplier never finishes, then recovers on the next op
        step();
        never_done = 1'b1;
        base = rsp_cnt;
        issue(0, 128'd5, 128'd6, 1'b1);
        ic = iss_cyc;
        wait_rsps(base + 1, 60);
        check_eq("timeout_rsp_lat", rsp_cyc[0] - ic, 20);
        never_done = 1'b0;
        issue(0, 128'd5, 128'd6, 1'b0);
        wait_rsps(base + 2, 60);
`endif

        repeat (5) step();
        begin
            int left;
            left = 0;
            for (int i = 0; i < NREQ; i++) left += exp_q[i].size();
            check_eq("scoreboard_drained", left, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
